// File: rtl/chipmunk_pkg.sv
// rtl/chipmunk_pkg.sv - shared state, status and opcode definitions for the chipmunk session controller
package chipmunk_pkg;

  typedef enum logic [2:0] {
    sIdle = 3'd0,
    sLoad = 3'd1,
    sRun  = 3'd2,
    sDump = 3'd3,
    sDone = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'd0,
    STAT_OK      = 2'd1,
    STAT_TIMEOUT = 2'd2
  } status_t;

  localparam logic [7:0] HALT_OPCODE = 8'h83;

endpackage

// File: rtl/chipmunk_watchdog.sv
// rtl/chipmunk_watchdog.sv - clear/enable run-cycle counter with terminal-count flag
module chipmunk_watchdog #(
  parameter int WIDTH = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // All-ones marks the last of 2^WIDTH enabled cycles.
  assign o_expired = &r_count;

endmodule

// File: rtl/chipmunk_session_ctrl.sv
// rtl/chipmunk_session_ctrl.sv - load/run/dump session sequencer owning the shared CPU/host RAM port
module chipmunk_session_ctrl #(
  parameter int addrSize    = 12,
  parameter int timeoutBits = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [addrSize-1:0] i_loadAddr,
  input  logic [addrSize-1:0] i_loadLen,
  input  logic [addrSize-1:0] i_dumpAddr,
  input  logic [addrSize-1:0] i_dumpLen,
  input  logic [7:0]          i_inData,
  input  logic                i_inValid,
  output logic                o_inReady,
  output logic [7:0]          o_outData,
  output logic                o_outValid,
  input  logic                i_outReady,
  input  logic [addrSize-1:0] i_cpuAddr,
  input  logic [7:0]          i_cpuWriteData,
  input  logic                i_cpuWe,
  input  logic                i_cpuDone,
  output logic                o_cpuReset,
  output logic [addrSize-1:0] o_cpuStartPC,
  output logic [7:0]          o_cpuReadData,
  output logic [addrSize-1:0] o_memAddr,
  output logic [7:0]          o_memWriteData,
  output logic                o_memWe,
  input  logic [7:0]          i_memReadData,
  output logic                o_busy,
  output logic [1:0]          o_status
);
  import chipmunk_pkg::*;

  localparam logic [addrSize-1:0] ONE = addrSize'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [addrSize-1:0] r_ptr;
  logic [addrSize-1:0] r_load_addr;
  logic [addrSize-1:0] r_load_len;
  logic [addrSize-1:0] r_dump_addr;
  logic [addrSize-1:0] r_dump_len;
  logic                r_cpu_reset;
  logic                r_busy;
  status_t             r_status;

  logic w_load_fire, w_load_last, w_dump_active, w_dump_fire, w_dump_last, w_wd_expired;

  assign w_load_fire   = (r_state == sLoad) && i_inValid;
  assign w_load_last   = w_load_fire && (r_ptr == r_load_len - ONE);
  assign w_dump_active = (r_dump_len != '0);
  assign w_dump_fire   = (r_state == sDump) && w_dump_active && i_outReady;
  assign w_dump_last   = w_dump_fire && (r_ptr == r_dump_len - ONE);

  chipmunk_watchdog #(.WIDTH(timeoutBits)) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (r_state != sRun),
    .i_enable  (r_state == sRun),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= sIdle;
      r_ptr       <= '0;
      r_load_addr <= '0;
      r_load_len  <= '0;
      r_dump_addr <= '0;
      r_dump_len  <= '0;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_status    <= STAT_NONE;
    end else begin
      r_state     <= w_next_state;
      r_cpu_reset <= (w_next_state == sRun);
      case (r_state)
        sIdle, sDone: begin
          if (i_start) begin
            r_load_addr <= i_loadAddr;
            r_load_len  <= i_loadLen;
            r_dump_addr <= i_dumpAddr;
            r_dump_len  <= i_dumpLen;
            r_ptr       <= '0;
            r_status    <= STAT_NONE;
            r_busy      <= 1'b1;
          end
        end
        sLoad: begin
          if (w_load_fire) r_ptr <= w_load_last ? '0 : r_ptr + ONE;
        end
        sRun: begin
          // Halt takes priority when it coincides with watchdog expiry.
          if (i_cpuDone)         r_status <= STAT_OK;
          else if (w_wd_expired) r_status <= STAT_TIMEOUT;
        end
        sDump: begin
          if (w_dump_fire)           r_ptr  <= r_ptr + ONE;
          if (w_next_state == sDone) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state   = r_state;
    o_inReady      = 1'b0;
    o_outValid     = 1'b0;
    o_memAddr      = '0;
    o_memWriteData = '0;
    o_memWe        = 1'b1;
    case (r_state)
      sIdle, sDone: begin
        if (i_start) w_next_state = (i_loadLen == '0) ? sRun : sLoad;
      end
      sLoad: begin
        o_inReady      = 1'b1;
        o_memAddr      = r_load_addr + r_ptr;
        o_memWriteData = i_inData;
        // Strobe only in the clk-low half, same as the CPU's write enable.
        o_memWe        = !(i_inValid && !i_clk);
        if (w_load_last) w_next_state = sRun;
      end
      sRun: begin
        o_memAddr      = i_cpuAddr;
        o_memWriteData = i_cpuWriteData;
        o_memWe        = i_cpuWe;
        if (i_cpuDone || w_wd_expired) w_next_state = sDump;
      end
      sDump: begin
        o_memAddr  = r_dump_addr + r_ptr;
        o_outValid = w_dump_active;
        if (!w_dump_active || w_dump_last) w_next_state = sDone;
      end
      default: w_next_state = sIdle;
    endcase
  end

  assign o_outData     = i_memReadData;
  assign o_cpuReadData = i_memReadData;
  assign o_cpuStartPC  = r_load_addr;
  assign o_cpuReset    = r_cpu_reset;
  assign o_busy        = r_busy;
  assign o_status      = r_status;

endmodule

// File: tb/tb_chipmunk_session_ctrl.sv
// tb/tb_chipmunk_session_ctrl.sv - directed self-checking bench for chipmunk_session_ctrl
module tb_chipmunk_session_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [11:0] loadAddr, loadLen, dumpAddr, dumpLen;
  logic [7:0]  inData;
  logic        inValid, inReady;
  logic [7:0]  outData;
  logic        outValid, outReady;
  logic [11:0] cpuAddr;
  logic [7:0]  cpuWriteData;
  logic        cpuWe, cpuDone, cpuReset;
  logic [11:0] cpuStartPC;
  logic [7:0]  cpuReadData;
  logic [11:0] memAddr;
  logic [7:0]  memWriteData;
  logic        memWe;
  logic [7:0]  memReadData;
  logic        busy;
  logic [1:0]  status;

  logic [7:0]  mem [0:4095];
  logic [7:0]  got[$], exp_q[$], ld_q[$];
  logic [11:0] wq[$], exp_a[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  assign memReadData = mem[memAddr];

  // RAM model: commits a write strobed low during the clk-low half.
  always @(negedge clk) begin
    #2;
    if (!memWe) begin
      mem[memAddr] = memWriteData;
      wq.push_back(memAddr);
    end
  end

  chipmunk_session_ctrl #(.addrSize(12), .timeoutBits(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_loadAddr(loadAddr), .i_loadLen(loadLen), .i_dumpAddr(dumpAddr), .i_dumpLen(dumpLen),
    .i_inData(inData), .i_inValid(inValid), .o_inReady(inReady),
    .o_outData(outData), .o_outValid(outValid), .i_outReady(outReady),
    .i_cpuAddr(cpuAddr), .i_cpuWriteData(cpuWriteData), .i_cpuWe(cpuWe), .i_cpuDone(cpuDone),
    .o_cpuReset(cpuReset), .o_cpuStartPC(cpuStartPC), .o_cpuReadData(cpuReadData),
    .o_memAddr(memAddr), .o_memWriteData(memWriteData), .o_memWe(memWe),
    .i_memReadData(memReadData), .o_busy(busy), .o_status(status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [11:0] la, ll, da, dl);
    loadAddr = la; loadLen = ll; dumpAddr = da; dumpLen = dl;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load_bytes(input bit gap);
    for (int i = 0; i < ld_q.size(); i++) begin
      inData = ld_q[i]; inValid = 1'b1;
      cyc();
      if (gap) begin
        inValid = 1'b0; inData = 8'hEE;
        cyc();
      end
    end
    inValid = 1'b0;
  endtask

  task automatic halt_cpu();
    cpuDone = 1'b1;
    cyc();
    cpuDone = 1'b0;
  endtask

  task automatic do_dump();
    int n = 0;
    got.delete();
    while (busy && n < 40) begin
      if (outValid && outReady) got.push_back(outData);
      cyc();
      n++;
    end
    check("dump_finished", {31'd0, busy}, 32'd0);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic cmp_addrs(input string tag);
    check({tag, "_nwrites"}, wq.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++)
      if (i < wq.size()) check($sformatf("%s_addr%0d", tag, i), {20'd0, wq[i]}, {20'd0, exp_a[i]});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    reset = 1'b1; start = 1'b0; inValid = 1'b0; inData = 8'h00; outReady = 1'b0;
    loadAddr = '0; loadLen = '0; dumpAddr = '0; dumpLen = '0;
    cpuAddr = '0; cpuWriteData = '0; cpuWe = 1'b1; cpuDone = 1'b0;
    cyc(); cyc();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_status", {30'd0, status}, 0);
    check("rst_cpuReset", {31'd0, cpuReset}, 0);
    check("rst_inReady", {31'd0, inReady}, 0);
    check("rst_outValid", {31'd0, outValid}, 0);
    check("rst_memWe", {31'd0, memWe}, 1);
    reset = 1'b0;
    cyc();

    // Basic session with a halting program.
    wq.delete();
    start_session(12'h100, 12'd3, 12'h100, 12'd3);
    check("basic_inReady", {31'd0, inReady}, 1);
    check("basic_busy", {31'd0, busy}, 1);
    ld_q = '{8'h00, 8'h05, 8'h83};
    load_bytes(1'b0);
    check("basic_release", {31'd0, cpuReset}, 1);
    check("basic_startpc", {20'd0, cpuStartPC}, 32'h100);
    exp_a = '{12'h100, 12'h101, 12'h102};
    cmp_addrs("basic_load");
    check("basic_mem101", {24'd0, mem[12'h101]}, 32'h05);
    cpuAddr = 12'h102; #1;
    check("basic_cpu_rd", {24'd0, cpuReadData}, 32'h83);
    cpuAddr = 12'h200; cpuWriteData = 8'h5A; cpuWe = 1'b0; #1;
    check("basic_cpu_we", {31'd0, memWe}, 0);
    cyc();
    cpuWe = 1'b1;
    check("basic_cpu_wr", {24'd0, mem[12'h200]}, 32'h5A);
    halt_cpu();
    check("basic_status_ok", {30'd0, status}, 1);
    check("basic_cpu_held", {31'd0, cpuReset}, 0);
    check("basic_outValid", {31'd0, outValid}, 1);
    outReady = 1'b1;
    do_dump();
    exp_q = '{8'h00, 8'h05, 8'h83};
    cmp_stream("basic_dump");
    check("basic_done_status", {30'd0, status}, 1);

    // Watchdog: CPU never signals done.
    start_session(12'h000, 12'd2, 12'h000, 12'd2);
    ld_q = '{8'hC0, 8'h00};
    load_bytes(1'b0);
    n = 0;
    while (cpuReset && n < 40) begin
      n++;
      cyc();
    end
    check("wd_run_cycles", n, 16);
    check("wd_status", {30'd0, status}, 2);
    check("wd_outValid", {31'd0, outValid}, 1);
    do_dump();
    exp_q = '{8'hC0, 8'h00};
    cmp_stream("wd_dump");
    check("wd_cpu_low_done", {31'd0, cpuReset}, 0);

    // Backpressure on both streams.
    wq.delete();
    start_session(12'h300, 12'd4, 12'h300, 12'd4);
    ld_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_bytes(1'b1);
    exp_a = '{12'h300, 12'h301, 12'h302, 12'h303};
    cmp_addrs("bp_load");
    halt_cpu();
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_stall_data%0d", i), {24'd0, outData}, 32'h11);
      check($sformatf("bp_stall_valid%0d", i), {31'd0, outValid}, 1);
      cyc();
    end
    outReady = 1'b1;
    do_dump();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmp_stream("bp_dump");

    // loadLen == 0 goes straight to RUN.
    wq.delete();
    start_session(12'h050, 12'd0, 12'h101, 12'd1);
    check("ll0_run", {31'd0, cpuReset}, 1);
    check("ll0_inReady", {31'd0, inReady}, 0);
    halt_cpu();
    do_dump();
    exp_q = '{8'h05};
    cmp_stream("ll0_dump");
    check("ll0_nwrites", wq.size(), 0);

    // dumpLen == 0 skips the output stream.
    start_session(12'h400, 12'd1, 12'h000, 12'd0);
    ld_q = '{8'h77};
    load_bytes(1'b0);
    halt_cpu();
    check("dl0_outValid", {31'd0, outValid}, 0);
    cyc();
    check("dl0_busy", {31'd0, busy}, 0);
    check("dl0_status", {30'd0, status}, 1);

    // Address wrap at the top of RAM.
    wq.delete();
    start_session(12'hFFE, 12'd4, 12'hFFE, 12'd4);
    ld_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    load_bytes(1'b0);
    exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    cmp_addrs("wrap_load");
    halt_cpu();
    do_dump();
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    cmp_stream("wrap_dump");

    // Reset mid-LOAD after two of five bytes.
    wq.delete();
    start_session(12'h500, 12'd5, 12'h500, 12'd1);
    ld_q = '{8'h91, 8'h92};
    load_bytes(1'b0);
    reset = 1'b1;
    cyc();
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_cpuReset", {31'd0, cpuReset}, 0);
    check("mid_rst_status", {30'd0, status}, 0);
    check("mid_rst_inReady", {31'd0, inReady}, 0);
    reset = 1'b0; inValid = 1'b1; inData = 8'h93;
    cyc(); cyc(); cyc();
    inValid = 1'b0;
    check("mid_rst_nwrites", wq.size(), 2);

    // start during RUN is ignored and does not relatch.
    start_session(12'h600, 12'd1, 12'h600, 12'd1);
    ld_q = '{8'h42};
    load_bytes(1'b0);
    loadAddr = 12'h700; dumpAddr = 12'h700; loadLen = 12'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("ign_still_run", {31'd0, cpuReset}, 1);
    check("ign_startpc", {20'd0, cpuStartPC}, 32'h600);
    check("ign_busy", {31'd0, busy}, 1);
    halt_cpu();
    do_dump();
    exp_q = '{8'h42};
    cmp_stream("ign_dump");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chipmunk_session_ctrl.md
# chipmunk_session_ctrl

Session controller that owns the single program/data RAM port shared by the chipmunk CPU and a host byte stream. It holds the CPU in reset while a host program is streamed into RAM, then releases the CPU at a chosen start PC. It runs the CPU until the CPU halts (halt opcode 0x83) or a watchdog expires, then streams a result window of RAM back to the host.

## Interface
- addrSize, 12: RAM/CPU address width.
- timeoutBits, 16: watchdog counter width.

Ports:
- clk  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin session; honoured only in IDLE or DONE.
- loadAddr  in  addrSize  load base; also CPU start PC.
- loadLen  in  addrSize  bytes to load.
- dumpAddr  in  addrSize  result window base.
- dumpLen  in  addrSize  result window length.
- inData  in  8  load byte.
- inValid  in  1  inData valid.
- inReady  out  1  controller accepts inData.
- outData  out  8  dump byte.
- outValid  out  1  outData valid.
- outReady  in  1  host accepts outData.
- cpuAddr  in  addrSize  CPU addrBus.
- cpuWriteData  in  8  CPU dataBusWrite.
- cpuWe  in  1  CPU weMem, active-low, already qualified to the clk-low half.
- cpuDone  in  1  CPU done.
- cpuReset  out  1  CPU reset, active-low.
- cpuStartPC  out  addrSize  CPU startPC.
- cpuReadData  out  8  CPU dataBus.
- memAddr  out  addrSize  RAM address.
- memWriteData  out  8  RAM write data.
- memWe  out  1  RAM write enable, active-low.
- memReadData  in  8  RAM asynchronous read data.
- busy  out  1  session in progress.
- status  out  2  0 none, 1 halted OK, 2 watchdog timeout.

## Operation
States are IDLE, LOAD, RUN, DUMP and DONE. The controller uses a byte pointer `ptr` (addrSize bits) and a watchdog counter `wd`.

- **IDLE/DONE, start=1:** latch all four address/length inputs.
  - Clear ptr.
  - Next state is LOAD, or RUN if loadLen==0.
  - status←0 and busy←1.
- **LOAD:**
  - inReady=1.
  - When inValid, write inData to RAM[(loadAddr+ptr) mod 2^addrSize] and increment ptr.
  - On the write of byte loadLen−1, clear ptr and wd, then go to RUN.
- **RUN:**
  - cpuReset=1. The RAM port is connected straight through: memAddr=cpuAddr, memWriteData=cpuWriteData, memWe=cpuWe, cpuReadData=memReadData.
  - wd increments each cycle.
  - cpuDone=1: status←1, go to DUMP.
  - Else wd==all-ones: status←2, go to DUMP.
  - If both are true in the same cycle, done wins.
- **DUMP:**
  - Entered with ptr=0. Go straight to DONE if dumpLen==0.
  - Drive memAddr=(dumpAddr+ptr) mod 2^addrSize, outData=memReadData, outValid=1.
  - On outReady, increment ptr. After byte dumpLen−1, go to DONE.
- **DONE:** busy←0 and status is held until the next start.
- **Writes outside the active window:**
  - Loader writes assert memWe only during clk-low, matching the CPU convention (memWe = !(inValid & inReady & !clk)).
  - memWe=1 (inactive) in IDLE, DUMP and DONE.
- **CPU reset:** cpuReset=0 in every state except RUN. This also clears the CPU's latched done.
- **Ignored start:** start in LOAD, RUN or DUMP is ignored.
- **cpuStartPC:** equals the latched loadAddr.

## Timing
- **Reset values:** state=IDLE, cpuReset=0, busy=0, status=0, ptr=0, wd=0, inReady=0, outValid=0, memWe=1.
- **Reset mid-session:** reset in any state aborts to these values on the next edge. No partial write completes after the reset edge.
- **Registered outputs:** state, ptr, wd, cpuReset, busy and status are registered. inReady, outValid and the RAM mux decode combinationally from the state register.
- **Start latency:** start sampled at edge N puts the controller in LOAD at N+1.
- **Load throughput:** one byte per cycle when inValid is held high.
- **CPU release:** cpuReset rises in the first RUN cycle. The CPU fetches from loadAddr in that cycle.
- **Halt latency:** cpuDone high at edge N puts the controller in DUMP at N+1. cpuReset returns low in the same cycle.
- **Watchdog:** timeout fires after exactly 2^timeoutBits RUN cycles.
- **Output hold:** outData/outValid hold stable until outReady. Throughput is one byte per cycle.

## Structure
- **Shared package chipmunk_pkg:** state encodings (sIdle…sDone), status codes (STAT_NONE/OK/TIMEOUT) and the halt opcode constant 8'h83.
- **Sub-module chipmunk_watchdog:** clear/enable counter with a terminal-count flag. The RAM mux stays inline.

## Test plan
- **Basic session:**
  - Stimulus: loadAddr=0x100, loadLen=3, bytes {0x00,0x05,0x83}; dumpAddr=0x100, dumpLen=3; outReady=1.
  - Required: RUN for a few cycles, status=1, out stream {0x00,0x05,0x83}, busy=0.
- **Watchdog timeout:**
  - Stimulus: timeoutBits=4, program is a BRA-to-self loop.
  - Required: DUMP entered after exactly 16 RUN cycles, status=2, cpuReset low from then on.
- **Backpressure:**
  - Stimulus: inValid toggled 1/0 during LOAD; outReady low for 5 cycles in DUMP.
  - Required: bytes land at consecutive addresses; outData stable while stalled; no byte dropped or duplicated.
- **Boundaries:**
  - Stimulus: loadLen=0, then separately dumpLen=0; loadAddr=0xFFE with loadLen=4.
  - Required: LOAD and DUMP skipped respectively; writes go to 0xFFE, 0xFFF, 0x000, 0x001.
- **Reset and ignored start:**
  - Stimulus: reset asserted mid-LOAD after 2 of 5 bytes; start pulsed during RUN.
  - Required: IDLE, cpuReset=0, status=0 on the next edge; no further RAM writes; start during RUN has no effect.
